// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds FSM encodings, data width default, grant reset and RR pick.
package mux_arb_pkg;

  localparam int DATA_W_DEF = 16;
  localparam logic [1:0] LAST_GRANT_RST = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Round-robin pick: first set bit at last+1, last+2, ... wrapping.
  // Offset 4 aliases back to last itself, so a lone requester that
  // held the previous grant can still win from IDLE.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] last
  );
    logic [1:0] idx;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      idx = last + 2'(i);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/mux4to1_16bit.sv
// Plain 4:1 word selector used by the arbiter data path.
// Ports: sel (2b), d0..d3 (W each), y (W) = d[sel].
module mux4to1_16bit #(
  parameter int W = 16
) (
  input  logic [1:0]   sel,
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  output logic [W-1:0] y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0: y = d0;
      2'd1: y = d1;
      2'd2: y = d2;
      2'd3: y = d3;
      default: y = d0;
    endcase
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// 4-requester round-robin arbiter with valid/ready output stage.
// Ports: clk, rst (sync high), req[3:0], x0..x3, ack[3:0],
// out_valid/out_ready/out_data/out_sel. MUX4_ARB_COUNT_EN adds
// 16-bit grant counters gnt_cnt0..gnt_cnt3.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] x3,
  output logic [3:0]        ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel
`ifdef MUX4_ARB_COUNT_EN
  ,
  output logic [15:0]       gnt_cnt0,
  output logic [15:0]       gnt_cnt1,
  output logic [15:0]       gnt_cnt2,
  output logic [15:0]       gnt_cnt3
`endif
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        last_q, last_d;

  logic              hs;
  logic [3:0]        req_m;
  logic [1:0]        last_eff;
  logic [1:0]        nxt_sel;
  logic [DATA_W-1:0] mux_y;

  assign hs = (state_q == SEND) & out_ready;

  // The word just accepted must not win again in the same cycle.
  assign req_m    = hs ? (req & ~(4'b0001 << sel_q)) : req;
  assign last_eff = hs ? sel_q : last_q;
  assign nxt_sel  = rr_pick(req_m, last_eff);

  mux4to1_16bit #(
    .W(DATA_W)
  ) u_mux (
    .sel(nxt_sel),
    .d0 (x0),
    .d1 (x1),
    .d2 (x2),
    .d3 (x3),
    .y  (mux_y)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (hs) last_d = sel_q;
    unique case (state_q)
      IDLE: begin
        if (|req_m) begin
          state_d = SEND;
          data_d  = mux_y;
          sel_d   = nxt_sel;
        end
      end
      SEND: begin
        if (hs) begin
          if (|req_m) begin
            data_d = mux_y;
            sel_d  = nxt_sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= LAST_GRANT_RST;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  // A word pending when reset hits is dropped without an ack.
  assign ack       = {4{hs & ~rst}} & (4'b0001 << sel_q);
  assign out_valid = (state_q == SEND);
  assign out_data  = data_q;
  assign out_sel   = sel_q;

`ifdef MUX4_ARB_COUNT_EN
  logic [15:0] cnt_q [4];
  logic [15:0] cnt_d [4];

  always_comb begin
    cnt_d = cnt_q;
    if (hs) cnt_d[sel_q] = cnt_q[sel_q] + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign gnt_cnt0 = cnt_q[0];
  assign gnt_cnt1 = cnt_q[1];
  assign gnt_cnt2 = cnt_q[2];
  assign gnt_cnt3 = cnt_q[3];
`endif

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter: DATA_W, 16, width of every data path.
REQ-002 SHALL have ports, one per line:
- clk  input  1  sole clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request per requester i (bit i)
- x0..x3  input  DATA_W each  requester data words; held stable while req[i]=1 until ack[i]
- ack  output  4  acceptance pulse per requester
- out_valid  output  1  out_data holds a word
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  granted word
- out_sel  output  2  index of the granted requester
REQ-003 SHALL use one clock with synchronous, active-high reset, as already decided.

Function
REQ-004 SHALL implement a two-state FSM: IDLE (out_valid=0) and SEND (out_valid=1).
REQ-005 IDLE: if req!=0, SHALL select the winner, register out_sel and out_data, and enter SEND on the next edge, giving 1-cycle latency from req to out_valid.
REQ-006 Arbitration SHALL be round-robin: search starts at (last_grant+1) mod 4 and wraps 3->0.
REQ-007 Handshake SHALL occur when out_valid=1 and out_ready=1; ack[i] SHALL be combinational and equal out_valid & out_ready & (out_sel==i).
REQ-008 In SEND without a handshake, out_data, out_sel and out_valid SHALL hold unchanged.
REQ-009 On handshake, last_grant SHALL become out_sel.
REQ-010 On handshake, req[out_sel] SHALL be masked for that cycle's arbitration.
REQ-011 On handshake with any remaining unmasked req, the FSM SHALL load the new winner and stay in SEND, sustaining one word per cycle.
REQ-012 On handshake with no remaining unmasked req, the FSM SHALL return to IDLE.
REQ-013 If req[out_sel] drops during SEND, the captured word SHALL still be delivered and ack SHALL still pulse.
REQ-014 The data path SHALL be pure selection with no arithmetic; out_data SHALL equal x[out_sel] as sampled at the grant edge.

Reset
REQ-015 rst SHALL force IDLE, out_valid=0, out_data=0, out_sel=0, and last_grant=3, so requester 0 has highest priority after reset.
REQ-016 rst asserted in SEND SHALL discard the pending word, and no ack SHALL be issued in that cycle.

Configuration
REQ-017 With macro MUX4_ARB_COUNT_EN defined, the block SHALL add output ports gnt_cnt0..gnt_cnt3, each 16 bits.
REQ-018 With MUX4_ARB_COUNT_EN defined, each gnt_cnt SHALL increment on every handshake for its index, wrap 0xFFFF->0x0000, and reset to 0.
REQ-019 Without MUX4_ARB_COUNT_EN, the counter ports and logic SHALL be absent, with otherwise identical behaviour.

Structure
REQ-020 Shared package mux_arb_pkg SHALL hold the FSM state encodings (IDLE, SEND), the DATA_W default of 16 and the reset value of last_grant.
REQ-021 Data selection SHALL be done by one instance of the existing mux4to1_16bit sub-module, driven by the arbiter's next-select signal; the arbiter SHALL contain no duplicate mux.

Verification
REQ-022 Single request, out_ready=1: x0=0x1234, x1=0x5678, x2=0x9ABC, x3=0xDEF0, req=0010 -> next cycle out_valid=1, out_sel=1, out_data=0x5678, ack=0010.
REQ-023 All requesters asserted, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, with out_data 0x1234, 0x5678, 0x9ABC, 0xDEF0, 0x1234.
REQ-024 Backpressure: req=0100, out_ready=0 for 5 cycles -> out_data=0x9ABC held, ack=0; out_ready=1 -> ack=0100 for exactly one cycle.
REQ-025 Masking: only req[3] held high across its handshake -> no back-to-back re-grant; one IDLE cycle, then out_sel=3 again.
REQ-026 Reset mid-SEND with out_ready=0 -> next cycle out_valid=0, out_data=0, no ack; the first grant after reset goes to requester 0 when req=1111.
REQ-027 With MUX4_ARB_COUNT_EN: 65537 handshakes on requester 2 -> gnt_cnt2=1, other counters 0.
